// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: per-register latency countdown that holds ID instructions on load-use hazards
module load_use_scoreboard #(
   parameter int  NUM_ISSUE = 2,
   parameter int  LAT_W     = 2,
   parameter int  NREG      = 32,
   localparam int RW        = $clog2(NREG)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_ISSUE-1:0]       id_valid,
   input  logic [NUM_ISSUE*RW-1:0]    id_rs,
   input  logic [NUM_ISSUE*RW-1:0]    id_rt,
   input  logic [NUM_ISSUE*2-1:0]     id_rsrt_read,
   input  logic [NUM_ISSUE-1:0]       id_fire,
   input  logic [NUM_ISSUE*RW-1:0]    id_wr_reg,
   input  logic [NUM_ISSUE-1:0]       id_wr_en,
   input  logic [NUM_ISSUE*LAT_W-1:0] id_wr_lat,
   input  logic                       pipe_freeze,
   input  logic                       flush,
   output logic [NUM_ISSUE-1:0]       slot_stall,
   output logic [LAT_W-1:0]           stall_lat,
   output logic [31:0]                perf_stall_cnt
);
   logic [LAT_W-1:0]     cnt_q [NREG];
   logic [LAT_W-1:0]     cnt_d [NREG];
   logic [31:0]          perf_q, perf_d;
   logic [NUM_ISSUE-1:0] src_hazard;
   logic [LAT_W-1:0]     lat_rs, lat_rt;

   // countdown unless frozen, then loads in program order so slot 1 wins, flush wipes everything
   always_comb begin
      for (int r = 0; r < NREG; r++)
         cnt_d[r] = (|cnt_q[r] && !pipe_freeze) ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
      for (int i = 0; i < NUM_ISSUE; i++)
         if (id_fire[i] && id_valid[i] && id_wr_en[i] && |id_wr_reg[i*RW +: RW] && |id_wr_lat[i*LAT_W +: LAT_W])
            cnt_d[id_wr_reg[i*RW +: RW]] = id_wr_lat[i*LAT_W +: LAT_W];
      if (flush)
         for (int r = 0; r < NREG; r++)
            cnt_d[r] = '0;
      cnt_d[0] = '0;
   end

   // a slot is blocked when any source it reads still has a pending countdown
   always_comb begin
      for (int i = 0; i < NUM_ISSUE; i++)
         src_hazard[i] = id_valid[i] &&
            ((id_rsrt_read[2*i+1] && |id_rs[i*RW +: RW] && |cnt_q[id_rs[i*RW +: RW]]) ||
             (id_rsrt_read[2*i]   && |id_rt[i*RW +: RW] && |cnt_q[id_rt[i*RW +: RW]]));
   end

   assign slot_stall[0] = src_hazard[0];

   generate
      if (NUM_ISSUE == 2) begin : g_dual
         logic [RW-1:0] wr0;
         logic          raw;
         assign wr0 = id_wr_reg[RW-1:0];
         assign raw = id_valid[0] && id_wr_en[0] && |wr0 &&
                      ((id_rsrt_read[3] && id_rs[2*RW-1:RW] == wr0) ||
                       (id_rsrt_read[2] && id_rt[2*RW-1:RW] == wr0));
         assign slot_stall[1] = src_hazard[1] || src_hazard[0] || raw;
      end
   endgenerate

   assign lat_rs         = id_rsrt_read[1] ? cnt_q[id_rs[RW-1:0]] : '0;
   assign lat_rt         = id_rsrt_read[0] ? cnt_q[id_rt[RW-1:0]] : '0;
   assign stall_lat      = !src_hazard[0] ? '0 : (lat_rs > lat_rt ? lat_rs : lat_rt);
   assign perf_d         = (src_hazard[0] && !pipe_freeze && !flush && ~&perf_q) ? perf_q + 32'd1 : perf_q;
   assign perf_stall_cnt = perf_q;

   // state register; reset discards any countdown in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++)
            cnt_q[r] <= '0;
         perf_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         perf_q <= perf_d;
      end
   end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: randomized and directed checks against a per-register remaining-latency model
module tb_load_use_scoreboard;
   logic        clk, rst;
   logic [1:0]  id_valid, id_fire, id_wr_en;
   logic [9:0]  id_rs, id_rt, id_wr_reg;
   logic [3:0]  id_rsrt_read, id_wr_lat;
   logic        pipe_freeze, flush;
   logic [1:0]  slot_stall;
   logic [1:0]  stall_lat;
   logic [31:0] perf_stall_cnt;

   int          rem [32];
   logic [31:0] m_perf;
   int          checks, errors;

   load_use_scoreboard dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rsrt_read(id_rsrt_read), .id_fire(id_fire), .id_wr_reg(id_wr_reg),
      .id_wr_en(id_wr_en), .id_wr_lat(id_wr_lat), .pipe_freeze(pipe_freeze),
      .flush(flush), .slot_stall(slot_stall), .stall_lat(stall_lat),
      .perf_stall_cnt(perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int f_rs(int i);  return int'(id_rs[i*5 +: 5]);     endfunction
   function automatic int f_rt(int i);  return int'(id_rt[i*5 +: 5]);     endfunction
   function automatic int f_wr(int i);  return int'(id_wr_reg[i*5 +: 5]); endfunction
   function automatic int f_lat(int i); return int'(id_wr_lat[i*2 +: 2]); endfunction

   function automatic void model_out(output logic [1:0] es, output logic [1:0] el);
      bit h [2];
      bit raw;
      int mx;
      for (int i = 0; i < 2; i++) begin
         h[i] = 0;
         if (id_rsrt_read[2*i+1] && f_rs(i) != 0 && rem[f_rs(i)] > 0) h[i] = 1;
         if (id_rsrt_read[2*i]   && f_rt(i) != 0 && rem[f_rt(i)] > 0) h[i] = 1;
         h[i] = h[i] && id_valid[i];
      end
      raw = id_valid[0] && id_wr_en[0] && f_wr(0) != 0 &&
            ((id_rsrt_read[3] && f_rs(1) == f_wr(0)) || (id_rsrt_read[2] && f_rt(1) == f_wr(0)));
      es[0] = h[0];
      es[1] = h[1] || h[0] || raw;
      mx = 0;
      if (id_rsrt_read[1] && rem[f_rs(0)] > mx) mx = rem[f_rs(0)];
      if (id_rsrt_read[0] && rem[f_rt(0)] > mx) mx = rem[f_rt(0)];
      el = es[0] ? mx[1:0] : 2'd0;
   endfunction

   function automatic void model_step(bit st0);
      if (rst) begin
         foreach (rem[r]) rem[r] = 0;
         m_perf = 0;
         return;
      end
      if (flush) begin
         foreach (rem[r]) rem[r] = 0;
         return;
      end
      if (st0 && !pipe_freeze && m_perf != 32'hFFFF_FFFF) m_perf++;
      if (!pipe_freeze)
         foreach (rem[r]) if (rem[r] > 0) rem[r]--;
      for (int i = 0; i < 2; i++)
         if (id_fire[i] && id_valid[i] && id_wr_en[i] && f_wr(i) != 0 && f_lat(i) != 0)
            rem[f_wr(i)] = f_lat(i);
   endfunction

   task automatic cycle();
      logic [1:0] es, el;
      #1;
      model_out(es, el);
      chk("slot_stall", 32'(slot_stall), 32'(es));
      chk("stall_lat", 32'(stall_lat), 32'(el));
      chk("perf_stall_cnt", perf_stall_cnt, m_perf);
      model_step(es[0]);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = '0; id_fire = '0; id_wr_en = '0; id_rs = '0; id_rt = '0;
      id_wr_reg = '0; id_rsrt_read = '0; id_wr_lat = '0; pipe_freeze = 0; flush = 0;
   endtask

   task automatic set_slot(int i, int v, int rs, int rt, int rrs, int rrt, int f, int wr, int we, int lat);
      id_valid[i]          = v != 0;
      id_rs[i*5 +: 5]      = rs[4:0];
      id_rt[i*5 +: 5]      = rt[4:0];
      id_rsrt_read[2*i+1]  = rrs != 0;
      id_rsrt_read[2*i]    = rrt != 0;
      id_fire[i]           = f != 0;
      id_wr_reg[i*5 +: 5]  = wr[4:0];
      id_wr_en[i]          = we != 0;
      id_wr_lat[i*2 +: 2]  = lat[1:0];
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   task automatic load0(int r, int lat);
      idle();
      set_slot(0, 1, 0, 0, 0, 0, 1, r, 1, lat);
      cycle();
      idle();
   endtask

   initial begin
      checks = 0; errors = 0; m_perf = 0;
      foreach (rem[r]) rem[r] = 0;
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;

      // reset state: nothing pending, only intra-bundle RAW can stall
      set_slot(0, 1, 5, 6, 1, 1, 0, 0, 0, 0);
      #1 chk("rst_stall", 32'(slot_stall), 32'd0);
      chk("rst_perf", perf_stall_cnt, 32'd0);
      cycle();
      idle();
      set_slot(0, 1, 0, 0, 0, 0, 0, 3, 1, 0);
      set_slot(1, 1, 0, 3, 0, 1, 0, 0, 0, 0);
      #1 chk("rst_raw", 32'(slot_stall), 32'd2);
      cycle();

      // load-use countdown 3,2,1
      do_reset();
      load0(5, 3);
      set_slot(0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 3; k >= 1; k--) begin
         #1 chk("lu_stall", 32'(slot_stall[0]), 32'd1);
         chk("lu_lat", 32'(stall_lat), 32'(k));
         cycle();
      end
      #1 chk("lu_free", 32'(slot_stall[0]), 32'd0);
      chk("lu_perf", perf_stall_cnt, 32'd3);
      cycle();

      // freeze holds the counter
      do_reset();
      load0(5, 3);
      set_slot(0, 1, 5, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         pipe_freeze = (k == 1 || k == 2);
         #1 chk("frz_stall", 32'(slot_stall[0]), 32'd1);
         chk("frz_lat", 32'(stall_lat), (k == 0) ? 32'd3 : (k == 4) ? 32'd1 : 32'd2);
         cycle();
      end
      pipe_freeze = 0;
      #1 chk("frz_free", 32'(slot_stall[0]), 32'd0);
      chk("frz_perf", perf_stall_cnt, 32'd3);
      cycle();

      // dual issue: MFC0 in slot 0, consumer in slot 1
      do_reset();
      set_slot(0, 1, 0, 0, 0, 0, 1, 8, 1, 2);
      set_slot(1, 1, 8, 0, 1, 0, 0, 0, 0, 0);
      #1 chk("dual_raw", 32'(slot_stall), 32'd2);
      cycle();
      idle();
      set_slot(1, 1, 8, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         #1 chk("dual_wait", 32'(slot_stall), 32'd2);
         cycle();
      end
      #1 chk("dual_free", 32'(slot_stall), 32'd0);
      cycle();

      // same-cycle writes: slot 1 latency wins
      do_reset();
      set_slot(0, 1, 0, 0, 0, 0, 1, 9, 1, 3);
      set_slot(1, 1, 0, 0, 0, 0, 1, 9, 1, 1);
      cycle();
      idle();
      set_slot(0, 1, 0, 9, 0, 1, 0, 0, 0, 0);
      #1 chk("sw_lat", 32'(stall_lat), 32'd1);
      cycle();
      #1 chk("sw_free", 32'(slot_stall[0]), 32'd0);
      cycle();

      // $0 never tracked; flush clears counters
      do_reset();
      set_slot(0, 1, 0, 0, 0, 0, 1, 0, 1, 3);
      set_slot(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      #1 chk("r0_raw", 32'(slot_stall), 32'd0);
      cycle();
      idle();
      set_slot(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      #1 chk("r0_read", 32'(slot_stall[0]), 32'd0);
      cycle();
      load0(4, 3);
      set_slot(0, 1, 4, 0, 1, 0, 0, 0, 0, 0);
      flush = 1;
      #1 chk("fl_before", 32'(stall_lat), 32'd3);
      cycle();
      flush = 0;
      #1 chk("fl_after", 32'(slot_stall[0]), 32'd0);
      cycle();

      // reset mid-countdown, then saturation of the perf counter
      do_reset();
      load0(6, 3);
      set_slot(0, 1, 6, 0, 1, 0, 0, 0, 0, 0);
      rst = 1;
      cycle();
      rst = 0;
      #1 chk("rm_free", 32'(slot_stall[0]), 32'd0);
      chk("rm_perf", perf_stall_cnt, 32'd0);
      cycle();
      load0(7, 3);
      set_slot(0, 1, 7, 0, 1, 0, 0, 0, 0, 0);
      force dut.perf_q = 32'hFFFF_FFFE;
      #1 release dut.perf_q;
      m_perf = 32'hFFFF_FFFE;
      cycle();
      cycle();
      #1 chk("sat_perf", perf_stall_cnt, 32'hFFFF_FFFF);
      cycle();
      #1 chk("sat_hold", perf_stall_cnt, 32'hFFFF_FFFF);
      cycle();

      // randomized traffic on a small register window to provoke frequent hazards
      do_reset();
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 2; i++)
            set_slot(i, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
         pipe_freeze = $urandom_range(0, 4) == 0;
         flush       = $urandom_range(0, 19) == 0;
         rst         = $urandom_range(0, 63) == 0;
         cycle();
      end
      rst = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
